// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule. One round key is presented per valid/ready
// handshake. SubWord uses four byte S-boxes, followed by the XOR chain.

// AES forward S-box, a single combinational byte lookup.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [0:255][7:0] SboxLut = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SboxLut[data_i];

endmodule

module aes_key_expand #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [3:0] LastIdx = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] key_next;
  logic [7:0]   rcon_next;
  logic         handshake;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w = {w3[23:0], w3[31:24]};

  // SubWord: one S-box per byte lane of the rotated word.
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (rot_w[8*i +: 8]),
      .data_o (sub_w[8*i +: 8])
    );
  end

  // Next round key and rcon, derived from the key currently on the output.
  always_comb begin
    t_w       = sub_w ^ {rcon_q, 24'h0};
    n0        = w0 ^ t_w;
    n1        = w1 ^ n0;
    n2        = w2 ^ n1;
    n3        = w3 ^ n2;
    key_next  = {n0, n1, n2, n3};
    rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  assign handshake = (state_q == StRun) && rk_ready;

  // FSM next-state: load on start, advance on handshake, retire after key NR.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = 8'h01;
        end
      end
      StRun: begin
        if (handshake) begin
          if (idx_q == LastIdx) begin
            // Key and index are left on the outputs after the final key.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            key_d  = key_next;
            idx_d  = idx_q + 4'd1;
            rcon_d = rcon_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk_valid  = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 vectors, backpressure, start
// while running, reset mid-schedule and back-to-back schedules.
module tb_aes_key_expand;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] fips_key;
  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk1, zero_rk10;

  aes_key_expand #(.NR(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
    step(); step();
    n_tests++;
    if (rk_valid !== 1'b0 || round_key !== 128'h0 || round_idx !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b key=%h idx=%0d busy=%b done=%b, want all zero",
               rk_valid, round_key, round_idx, busy, done);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: valid=%b busy=%b, want 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_fips();
    key_in = fips_key; start = 1'b1; rk_ready = 1'b1;
    step();
    start = 1'b0; key_in = '0;
    for (int i = 0; i <= NR; i++) begin
      n_tests++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
          round_key !== fips_rk[i] || round_idx !== 4'(i)) begin
        n_fail++;
        $display("FAIL fips_rk%0d: valid=%b busy=%b done=%b key=%h idx=%0d, want 1 1 0 %h %0d",
                 i, rk_valid, busy, done, round_key, round_idx, fips_rk[i], i);
      end
      step();
    end
    n_tests++;
    if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 ||
        round_key !== fips_rk[10] || round_idx !== 4'd10) begin
      n_fail++;
      $display("FAIL fips_done: done=%b valid=%b busy=%b key=%h idx=%0d, want 1 0 0 %h 10",
               done, rk_valid, busy, round_key, round_idx, fips_rk[10]);
    end
    step();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_backpressure();
    int e, hs, cyc;
    logic rdy;
    key_in = fips_key; start = 1'b1; rk_ready = 1'b0;
    step();
    start = 1'b0;
    e = 0; hs = 0; cyc = 0;
    while (e <= NR && cyc < 400) begin
      n_tests++;
      if (rk_valid !== 1'b1 || done !== 1'b0 || round_key !== fips_rk[e] ||
          round_idx !== 4'(e)) begin
        n_fail++;
        $display("FAIL bp_cycle%0d: valid=%b done=%b key=%h idx=%0d, want 1 0 %h %0d",
                 cyc, rk_valid, done, round_key, round_idx, fips_rk[e], e);
      end
      rdy = 1'($urandom_range(0, 1));
      rk_ready = rdy;
      step();
      cyc++;
      if (rdy) begin
        hs++;
        e++;
      end
    end
    n_tests++;
    if (cyc >= 400 || hs !== 11 || done !== 1'b1 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: cycles=%0d handshakes=%0d done=%b valid=%b, want 11 1 0",
               cyc, hs, done, rk_valid);
    end
    rk_ready = 1'b0;
    step();
  endtask

  task automatic test_zero_key();
    key_in = '0; start = 1'b1; rk_ready = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (rk_valid !== 1'b1 || round_key !== 128'h0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL zero_rk0: valid=%b key=%h idx=%0d, want 1 0 0", rk_valid, round_key,
               round_idx);
    end
    step();
    n_tests++;
    if (round_key !== zero_rk1 || round_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL zero_rk1: key=%h idx=%0d, want %h 1", round_key, round_idx, zero_rk1);
    end
    for (int i = 0; i < 9; i++) step();
    n_tests++;
    if (round_key !== zero_rk10 || round_idx !== 4'd10 || rk_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_rk10: key=%h idx=%0d valid=%b, want %h 10 1", round_key, round_idx,
               rk_valid, zero_rk10);
    end
    step();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_done: done=%b, want 1", done);
    end
    step();
  endtask

  task automatic test_start_ignored();
    key_in = fips_key; start = 1'b1; rk_ready = 1'b1;
    step();
    key_in = 128'h0f0e0d0c0b0a09080706050403020100;
    step();
    start = 1'b0;
    n_tests++;
    if (round_key !== fips_rk[1] || round_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL ignore_rk1: key=%h idx=%0d, want %h 1", round_key, round_idx, fips_rk[1]);
    end
    for (int i = 0; i < 9; i++) step();
    n_tests++;
    if (round_key !== fips_rk[10] || round_idx !== 4'd10) begin
      n_fail++;
      $display("FAIL ignore_rk10: key=%h idx=%0d, want %h 10", round_key, round_idx,
               fips_rk[10]);
    end
    step();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_done: done=%b, want 1", done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    key_in = fips_key; start = 1'b1; rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if (round_idx !== 4'd5 || round_key !== fips_rk[5]) begin
      n_fail++;
      $display("FAIL mid_rk5: key=%h idx=%0d, want %h 5", round_key, round_idx, fips_rk[5]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b busy=%b done=%b, want 0 0 0", rk_valid, busy, done);
    end
    step();
    n_tests++;
    if (done !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_nodone: done=%b valid=%b, want 0 0", done, rk_valid);
    end
    key_in = '0; start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (rk_valid !== 1'b1 || round_key !== 128'h0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_restart_rk0: valid=%b key=%h idx=%0d, want 1 0 0", rk_valid,
               round_key, round_idx);
    end
    step();
    n_tests++;
    if (round_key !== zero_rk1 || round_idx !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_restart_rk1: key=%h idx=%0d, want %h 1", round_key, round_idx,
               zero_rk1);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    key_in = fips_key; start = 1'b1; rk_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= NR; i++) step();
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b, want 1", done);
    end
    key_in = '0; start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (rk_valid !== 1'b1 || busy !== 1'b1 || round_key !== 128'h0 || round_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_rk0: valid=%b busy=%b key=%h idx=%0d, want 1 1 0 0", rk_valid, busy,
               round_key, round_idx);
    end
    step();
    n_tests++;
    if (round_key !== zero_rk1) begin
      n_fail++;
      $display("FAIL b2b_rk1: key=%h, want %h", round_key, zero_rk1);
    end
    for (int i = 0; i < 10; i++) step();
    n_tests++;
    if (done !== 1'b1 || round_key !== zero_rk10) begin
      n_fail++;
      $display("FAIL b2b_second_done: done=%b key=%h, want 1 %h", done, round_key, zero_rk10);
    end
    step();
  endtask

  initial begin
    fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_rk1    = 128'h62636363626363636263636362636363;
    zero_rk10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    test_reset();
    test_fips();
    test_backpressure();
    test_zero_key();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
